// File: rtl/tc_slot_scheduler.sv
// tc_slot_scheduler: round-robin arbiter with time-boxed grants and a fixed guard gap
// Ports: clk_i/rst_n_i clock and async active-low reset; req_i request levels;
// release_i early end by current owner; grant_o one-hot grant; grant_valid_o any grant;
// grant_idx_o current or last grantee; expire_o timeout pulse; busy_o in GRANT or GUARD.
module tc_slot_scheduler #(
    parameter int NREQ         = 4,
    parameter int SLOT_CYCLES  = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    release_i,
    output logic [NREQ-1:0]         grant_o,
    output logic                    grant_valid_o,
    output logic [$clog2(NREQ)-1:0] grant_idx_o,
    output logic                    expire_o,
    output logic                    busy_o
);
    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(SLOT_CYCLES) + 1;
    localparam int GW = $clog2(GUARD_CYCLES) + 1;
    // Loading 2^k-N makes the MSB set on exactly the Nth increment.
    localparam logic [SW-1:0] SLOAD = SW'((1 << $clog2(SLOT_CYCLES)) - SLOT_CYCLES);
    localparam logic [GW-1:0] GLOAD = GW'((1 << $clog2(GUARD_CYCLES)) - GUARD_CYCLES);
    localparam logic [IW:0]   NR    = (IW+1)'(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     slot_cnt, slot_nxt, slot_inc;
    logic [GW-1:0]     guard_cnt, guard_nxt, guard_inc;
    logic [IW-1:0]     ptr, ptr_nxt, idx_nxt, k, win, ptr_adv;
    logic [NREQ-1:0]   grant_nxt, win_oh;
    logic [2*NREQ-1:0] dbl;
    logic [IW:0]       wsum, psum;
    logic              any, exp_nxt;

    // Rotating the doubled request vector by ptr puts the highest-priority
    // requester at bit 0; the lowest set bit is the offset from ptr.
    always_comb begin
        dbl = {req_i, req_i} >> ptr;
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (dbl[i]) k = IW'(i);
        any     = |req_i;
        wsum    = {1'b0, ptr} + {1'b0, k};
        win     = IW'(wsum >= NR ? wsum - NR : wsum);
        win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << win;
        psum    = {1'b0, grant_idx_o} + 1'b1;
        ptr_adv = IW'(psum >= NR ? psum - NR : psum);
    end

    assign slot_inc  = slot_cnt + 1'b1;
    assign guard_inc = guard_cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        guard_nxt = guard_cnt;
        ptr_nxt   = ptr;
        grant_nxt = grant_o;
        idx_nxt   = grant_idx_o;
        exp_nxt   = 1'b0;
        case (state)
            IDLE: if (any) begin
                grant_nxt = win_oh;
                idx_nxt   = win;
                slot_nxt  = SLOAD;
                state_nxt = GRANT;
            end
            GRANT: begin
                slot_nxt = slot_inc;
                if (release_i || slot_inc[SW-1]) begin
                    grant_nxt = '0;
                    exp_nxt   = ~release_i;
                    ptr_nxt   = ptr_adv;
                    guard_nxt = GLOAD;
                    state_nxt = GUARD;
                end
            end
            GUARD: begin
                guard_nxt = guard_inc;
                if (guard_inc[GW-1]) begin
                    state_nxt = any ? GRANT : IDLE;
                    grant_nxt = any ? win_oh : '0;
                    idx_nxt   = any ? win : grant_idx_o;
                    slot_nxt  = any ? SLOAD : slot_cnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            slot_cnt      <= SLOAD;
            guard_cnt     <= GLOAD;
            ptr           <= '0;
            grant_o       <= '0;
            grant_valid_o <= 1'b0;
            grant_idx_o   <= '0;
            expire_o      <= 1'b0;
        end else begin
            state         <= state_nxt;
            slot_cnt      <= slot_nxt;
            guard_cnt     <= guard_nxt;
            ptr           <= ptr_nxt;
            grant_o       <= grant_nxt;
            grant_valid_o <= |grant_nxt;
            grant_idx_o   <= idx_nxt;
            expire_o      <= exp_nxt;
        end
    end

    assign busy_o = state != IDLE;
endmodule

// File: tb/tb_tc_slot_scheduler.sv
// tb_tc_slot_scheduler: directed checks of grant timing, release, fairness and reset
module tb_tc_slot_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, rst5_n = 1'b0;
    logic [3:0] req = '0, req5 = '0;
    logic       rel = 1'b0, rel5 = 1'b0;
    logic [3:0] grant, grant5;
    logic [1:0] idx, idx5;
    logic       gv, gv5, expire, expire5, busy, busy5;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    tc_slot_scheduler dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .release_i(rel),
        .grant_o(grant), .grant_valid_o(gv), .grant_idx_o(idx),
        .expire_o(expire), .busy_o(busy)
    );

    tc_slot_scheduler #(.NREQ(4), .SLOT_CYCLES(5), .GUARD_CYCLES(3)) dut5 (
        .clk_i(clk), .rst_n_i(rst5_n), .req_i(req5), .release_i(rel5),
        .grant_o(grant5), .grant_valid_o(gv5), .grant_idx_o(idx5),
        .expire_o(expire5), .busy_o(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered on grant cycle 1; returns on the cycle after the guard, where
    // the next grant (if any) is already visible.
    task automatic grant_run(input string tag, input logic [3:0] oh, input logic [1:0] i, input int rel_at);
        for (int c = 1; c <= 16; c++) begin
            chk({tag, "_grant"}, grant, oh);
            chk({tag, "_idx"}, idx, i);
            chk({tag, "_gv"}, gv, 1'b1);
            if (c == rel_at) rel = 1'b1;
            step();
            rel = 1'b0;
            if (c == rel_at) break;
        end
        chk({tag, "_end_grant"}, grant, 4'b0);
        chk({tag, "_end_expire"}, expire, rel_at == 0);
        chk({tag, "_end_busy"}, busy, 1'b1);
        chk({tag, "_hold_idx"}, idx, i);
        step();
        chk({tag, "_guard2_grant"}, grant, 4'b0);
        chk({tag, "_guard2_expire"}, expire, 1'b0);
        step();
    endtask

    initial begin
        #12;
        chk("rst_grant", grant, 4'b0);
        chk("rst_gv", gv, 1'b0);
        chk("rst_idx", idx, 2'd0);
        chk("rst_expire", expire, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst5_grant", grant5, 4'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);
        req = 4'b0100;
        step();
        grant_run("t1", 4'b0100, 2'd2, 0);
        grant_run("rel3", 4'b0100, 2'd2, 3);
        req = 4'b0101;
        grant_run("rel16", 4'b0100, 2'd2, 16);
        grant_run("fair0", 4'b0001, 2'd0, 0);
        grant_run("fair2", 4'b0100, 2'd2, 0);
        req = 4'b1111;
        grant_run("rr0", 4'b0001, 2'd0, 0);
        grant_run("rr1", 4'b0010, 2'd1, 0);
        grant_run("rr2", 4'b0100, 2'd2, 0);
        grant_run("rr3", 4'b1000, 2'd3, 0);
        chk("rr0b_grant", grant, 4'b0001);
        chk("rr0b_idx", idx, 2'd0);
        step(); step(); step(); step();
        chk("pre_rst_grant", grant, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 4'b0);
        chk("async_rst_gv", gv, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_idx", idx, 2'd0);
        @(negedge clk);
        req = 4'b1010;
        rst_n = 1'b1;
        step();
        req = 4'b0000;
        grant_run("post_rst", 4'b0010, 2'd1, 2);
        chk("idle_again_busy", busy, 1'b0);
        chk("idle_again_grant", grant, 4'b0);
        chk("idle_again_idx", idx, 2'd1);
        req5 = 4'b0001;
        @(negedge clk);
        rst5_n = 1'b1;
        step();
        for (int g = 0; g < 2; g++) begin
            for (int c = 1; c <= 5; c++) begin
                chk("s5_grant", grant5, 4'b0001);
                chk("s5_expire_low", expire5, 1'b0);
                step();
            end
            for (int c = 1; c <= 3; c++) begin
                chk("s5_gap_grant", grant5, 4'b0);
                chk("s5_gap_expire", expire5, c == 1);
                step();
            end
        end
        chk("s5_regrant", grant5, 4'b0001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
